rom_download_bridge: RTL and testbench

Converts the byte stream delivered by `data_io` during a ROM download into 16-bit SDRAM write transactions. It sits between `data_io` and the two SDRAM write ports (CPU-ROM port 1, graphics port 2). It pairs adjacent bytes into word writes and splits the image into two regions by address. It buffers writes in a small FIFO, drives the toggle req/ack handshake, and raises `rom_loaded` once every byte is committed. It replaces the open-coded per-byte toggle logic in the arcade top levels.

---
 rtl/rom_dl_pkg.sv | 27 ++
 rtl/rom_download_bridge_if.sv | 28 ++
 rtl/rom_dl_fifo.sv | 59 +++++
 rtl/rom_download_bridge.sv | 183 ++++++++++++++++++
 tb/tb_rom_download_bridge.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download bridge: the pending-write entry and port ids.
package rom_dl_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_GFX = 1'b1;

  typedef struct packed {
    logic        port_sel;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } rom_wr_t;

  // Build a write entry from an absolute byte address, splitting the image by region.
  function automatic rom_wr_t make_entry(input logic [24:0] addr, input logic [24:0] base,
                                         input logic [1:0] ds, input logic [15:0] d);
    rom_wr_t     e;
    logic [24:0] rel;
    e.port_sel = (addr >= base) ? PORT_GFX : PORT_CPU;
    rel        = (addr >= base) ? (addr - base) : addr;
    e.a        = 23'(rel >> 1);
    e.ds       = ds;
    e.d        = d;
    return e;
  endfunction

endpackage

// File: rtl/rom_download_bridge_if.sv
// The two SDRAM write ports (CPU-ROM port 1, graphics port 2) with toggle req/ack.
interface rom_download_bridge_if;
  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req;
  logic        port2_ack;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        port_we;

  modport master (
    output port1_req, port1_a, port1_ds, port1_d,
    output port2_req, port2_a, port2_ds, port2_d,
    output port_we,
    input  port1_ack, port2_ack
  );

  modport slave (
    input  port1_req, port1_a, port1_ds, port1_d,
    input  port2_req, port2_a, port2_ds, port2_d,
    input  port_we,
    output port1_ack, port2_ack
  );
endinterface

// File: rtl/rom_dl_fifo.sv
// Small synchronous FIFO of pending SDRAM writes; push and pop may share a cycle.
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_sys,
  input  logic    reset,
  input  logic    push,
  input  rom_wr_t push_data,
  input  logic    pop,
  output rom_wr_t head,
  output logic    empty,
  output logic    full,
  output logic    drop
);

  localparam int AW = $clog2(DEPTH);

  rom_wr_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk_sys) begin
    // NOTE: storage is not reset; count gates every read, so stale data is never seen.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rom_download_bridge.sv
// Pairs data_io download bytes into 16-bit SDRAM writes, queues them and issues
// them over the toggle req/ack ports; flags completion and dropped writes.
module rom_download_bridge
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] REGION2_BASE = 25'h10000,
  parameter logic [7:0]  ROM_INDEX    = 8'd0,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  rom_download_bridge_if.master sdram,
  output logic        rom_loaded,
  output logic        overflow
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic        sel_q;
  logic        wr_last, downl_last, seen_dl;
  logic        held_valid;
  logic [24:0] held_addr;
  logic [7:0]  held_data;
  logic        pend_valid;
  rom_wr_t     pend_entry;

  logic        accept, downl_fall, downl_rise, pairs;
  rom_wr_t     held_entry, new_single, pair_entry;
  logic        push, hold_load, hold_clear, pend_load;
  rom_wr_t     push_data;
  rom_wr_t     head;
  logic        fifo_empty, fifo_full, fifo_drop, pop, ack_match;

  assign accept     = ioctl_wr & ~wr_last & ioctl_downl & (ioctl_index == ROM_INDEX);
  assign downl_fall = downl_last & ~ioctl_downl;
  assign downl_rise = ~downl_last & ioctl_downl;
  assign pairs      = held_valid & (ioctl_addr == held_addr + 25'd1);
  assign held_entry = make_entry(held_addr, REGION2_BASE, held_addr[0] ? 2'b10 : 2'b01,
                                 {held_data, held_data});
  assign new_single = make_entry(ioctl_addr, REGION2_BASE, ioctl_addr[0] ? 2'b10 : 2'b01,
                                 {ioctl_dout, ioctl_dout});
  assign pair_entry = make_entry(held_addr, REGION2_BASE, 2'b11, {ioctl_dout, held_data});

  // Pairer decision: at most one FIFO push per cycle, a second push is deferred.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latches).
    push       = 1'b0;
    push_data  = new_single;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    pend_load  = 1'b0;
    if (pend_valid) begin
      push      = 1'b1;
      push_data = pend_entry;
    end else if (accept) begin
      if (pairs) begin
        push       = 1'b1;
        push_data  = pair_entry;
        hold_clear = 1'b1;
      end else begin
        if (held_valid) begin
          push       = 1'b1;
          push_data  = held_entry;
          hold_clear = 1'b1;
        end
        if (!ioctl_addr[0])  hold_load = 1'b1;
        else if (held_valid) pend_load = 1'b1;
        else                 push      = 1'b1;
      end
    end else if (downl_fall && held_valid) begin
      push       = 1'b1;
      push_data  = held_entry;
      hold_clear = 1'b1;
    end
  end

  // Edge detectors, held byte and deferred second push.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_last    <= 1'b0;
      downl_last <= 1'b0;
      held_valid <= 1'b0;
      held_addr  <= '0;
      held_data  <= '0;
      pend_valid <= 1'b0;
      pend_entry <= '0;
    end else begin
      wr_last    <= ioctl_wr;
      downl_last <= ioctl_downl;
      if (hold_load) begin
        held_valid <= 1'b1;
        held_addr  <= ioctl_addr;
        held_data  <= ioctl_dout;
      end else if (hold_clear) begin
        held_valid <= 1'b0;
      end
      pend_valid <= pend_load;
      if (pend_load) pend_entry <= new_single;
    end
  end

  rom_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  assign ack_match = (sel_q == PORT_CPU) ? (sdram.port1_ack == sdram.port1_req)
                                         : (sdram.port2_ack == sdram.port2_req);
  assign pop           = (state == S_WAIT) & ack_match;
  assign sdram.port_we = ioctl_downl | (state != S_IDLE) | ~fifo_empty;

  // Issuer: one outstanding write, head entry stays in the FIFO until acknowledged.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state           <= S_IDLE;
      sel_q           <= PORT_CPU;
      sdram.port1_req <= sdram.port1_ack;
      sdram.port2_req <= sdram.port2_ack;
      sdram.port1_a   <= '0;
      sdram.port1_ds  <= '0;
      sdram.port1_d   <= '0;
      sdram.port2_a   <= '0;
      sdram.port2_ds  <= '0;
      sdram.port2_d   <= '0;
    end else begin
      case (state)
        S_IDLE: if (!fifo_empty) begin
          sel_q <= head.port_sel;
          if (head.port_sel == PORT_CPU) begin
            sdram.port1_a   <= head.a;
            sdram.port1_ds  <= head.ds;
            sdram.port1_d   <= head.d;
            sdram.port1_req <= ~sdram.port1_req;
          end else begin
            sdram.port2_a   <= head.a;
            sdram.port2_ds  <= head.ds;
            sdram.port2_d   <= head.d;
            sdram.port2_req <= ~sdram.port2_req;
          end
          state <= S_WAIT;
        end
        S_WAIT: if (ack_match) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion and overflow flags, both cleared when a new download starts.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
      seen_dl    <= 1'b0;
    end else if (downl_rise) begin
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
      seen_dl    <= 1'b1;
    end else begin
      if (fifo_drop) overflow <= 1'b1;
      if (seen_dl && !ioctl_downl && !held_valid && !pend_valid && fifo_empty &&
          (state == S_IDLE))
        rom_loaded <= 1'b1;
    end
  end

  // Keeps the full flag observable for the drop logic inside the FIFO only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_rom_download_bridge.sv
// Scoreboard bench: byte stimulus feeds a pairing model that queues expected
// writes per port; SDRAM responders pop and compare on every req toggle.
module tb_rom_download_bridge;

  localparam logic [24:0] REGION2_BASE = 25'h10000;
  localparam logic [7:0]  ROM_INDEX    = 8'd0;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_downl;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rom_loaded;
  logic        overflow;

  rom_download_bridge_if bus ();

  rom_download_bridge #(.REGION2_BASE(REGION2_BASE), .ROM_INDEX(ROM_INDEX), .FIFO_DEPTH(4)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl_downl (ioctl_downl),
    .ioctl_index (ioctl_index),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .sdram       (bus),
    .rom_loaded  (rom_loaded),
    .overflow    (overflow)
  );

  always #10 clk_sys = ~clk_sys;

  typedef struct {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;

  exp_t exp1_q[$];
  exp_t exp2_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ack_lat  = 0;
  bit   stall    = 1'b0;

  // Reference model state: at most one byte waiting for its odd partner.
  bit          m_held = 1'b0;
  logic [24:0] m_addr;
  logic [7:0]  m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_write(input logic [24:0] addr, input logic [1:0] ds, input logic [15:0] d);
    exp_t        e;
    logic [24:0] rel;
    rel  = (addr >= REGION2_BASE) ? addr - REGION2_BASE : addr;
    e.a  = 23'(rel >> 1);
    e.ds = ds;
    e.d  = d;
    if (addr >= REGION2_BASE) exp2_q.push_back(e);
    else                      exp1_q.push_back(e);
  endtask

  task automatic model_byte(input logic [24:0] addr, input logic [7:0] data);
    if (m_held && addr == m_addr + 25'd1) begin
      expect_write(m_addr, 2'b11, {data, m_data});
      m_held = 1'b0;
    end else begin
      if (m_held) expect_write(m_addr, 2'b01, {m_data, m_data});
      m_held = 1'b0;
      if (addr[0]) expect_write(addr, 2'b10, {data, data});
      else begin
        m_held = 1'b1;
        m_addr = addr;
        m_data = data;
      end
    end
  endtask

  task automatic model_flush();
    if (m_held) expect_write(m_addr, m_addr[0] ? 2'b10 : 2'b01, {m_data, m_data});
    m_held = 1'b0;
  endtask

  task automatic score(input int port, input logic [22:0] a, input logic [1:0] ds,
                       input logic [15:0] d);
    exp_t e;
    if (port == 1 && exp1_q.size() == 0 || port == 2 && exp2_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_write port%0d: got a=%0h ds=%0b d=%0h expected no write",
               port, a, ds, d);
    end else begin
      e = (port == 1) ? exp1_q.pop_front() : exp2_q.pop_front();
      check($sformatf("port%0d_write", port), {a, ds, d}, {e.a, e.ds, e.d});
    end
  endtask

  // Port 1 SDRAM responder and write monitor.
  initial begin : resp1
    logic [40:0] wr;
    logic        rq;
    bus.port1_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (bus.port1_req != bus.port1_ack) begin
        wr = {bus.port1_a, bus.port1_ds, bus.port1_d};
        rq = bus.port1_req;
        score(1, bus.port1_a, bus.port1_ds, bus.port1_d);
        check("port_we_busy1", bus.port_we, 1);
        repeat (ack_lat == 0 ? $urandom_range(1, 4) : ack_lat) @(negedge clk_sys);
        while (stall) @(negedge clk_sys);
        if (bus.port1_req == rq)
          check("port1_stable", {bus.port1_a, bus.port1_ds, bus.port1_d}, wr);
        bus.port1_ack = bus.port1_req;
      end
    end
  end

  // Port 2 SDRAM responder and write monitor.
  initial begin : resp2
    logic [40:0] wr;
    logic        rq;
    bus.port2_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (bus.port2_req != bus.port2_ack) begin
        wr = {bus.port2_a, bus.port2_ds, bus.port2_d};
        rq = bus.port2_req;
        score(2, bus.port2_a, bus.port2_ds, bus.port2_d);
        repeat (ack_lat == 0 ? $urandom_range(1, 4) : ack_lat) @(negedge clk_sys);
        while (stall) @(negedge clk_sys);
        if (bus.port2_req == rq)
          check("port2_stable", {bus.port2_a, bus.port2_ds, bus.port2_d}, wr);
        bus.port2_ack = bus.port2_req;
      end
    end
  end

  task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    if (ioctl_downl && idx == ROM_INDEX) model_byte(addr, data);
    repeat (2) @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (6 + $urandom_range(0, 4)) @(negedge clk_sys);
  endtask

  task automatic start_dl(input string name);
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    check({name, "_loaded_clr"}, rom_loaded, 0);
    check({name, "_overflow_clr"}, overflow, 0);
  endtask

  task automatic finish_dl(input string name);
    int n;
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
    model_flush();
    n = 0;
    while (!rom_loaded && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check({name, "_rom_loaded"}, rom_loaded, 1);
    check({name, "_drained"}, 64'(exp1_q.size() + exp2_q.size()), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        r1;
    logic [24:0] cur;
    int          n;
    reset       = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("reset_rom_loaded", rom_loaded, 0);
    check("reset_overflow", overflow, 0);
    check("reset_port_we", bus.port_we, 0);
    check("reset_port1_out", {bus.port1_a, bus.port1_ds, bus.port1_d}, 0);
    check("reset_req_idle", {bus.port1_req, bus.port2_req}, {bus.port1_ack, bus.port2_ack});

    // Adjacent pair on port 1.
    ack_lat = 3;
    start_dl("pair1");
    send_byte(8'd0, 25'd0, 8'hAA);
    send_byte(8'd0, 25'd1, 8'hBB);
    finish_dl("pair1");
    check("pair1_overflow", overflow, 0);

    // Pair in region 2; port 1 must stay quiet.
    r1 = bus.port1_req;
    start_dl("pair2");
    send_byte(8'd0, REGION2_BASE, 8'h12);
    send_byte(8'd0, REGION2_BASE + 25'd1, 8'h34);
    finish_dl("pair2");
    check("pair2_port1_quiet", bus.port1_req, r1);

    // Two lone even bytes: one flushed by the next byte, one by downl falling.
    start_dl("singles");
    send_byte(8'd0, 25'd4, 8'h55);
    send_byte(8'd0, 25'd8, 8'h66);
    finish_dl("singles");

    // Stalled acks: only FIFO_DEPTH entries survive, the rest are dropped.
    ack_lat = 1;
    stall   = 1'b1;
    start_dl("ovf");
    for (int i = 0; i < 6; i++) begin
      send_byte(8'd0, 25'h100 + 25'(2 * i), 8'(8'h10 + 2 * i));
      send_byte(8'd0, 25'h101 + 25'(2 * i), 8'(8'h11 + 2 * i));
    end
    // Pairs 5 and 6 arrive while four entries (including the one in flight) are held.
    void'(exp1_q.pop_back());
    void'(exp1_q.pop_back());
    check("ovf_overflow_set", overflow, 1);
    stall = 1'b0;
    finish_dl("ovf");
    check("ovf_overflow_sticky", overflow, 1);

    // Bytes on a foreign index are ignored.
    ack_lat = 0;
    r1 = bus.port1_req;
    start_dl("index");
    send_byte(8'd1, 25'd0, 8'h01);
    send_byte(8'd1, 25'd1, 8'h02);
    send_byte(8'd1, 25'd3, 8'h03);
    finish_dl("index");
    check("index_no_req", bus.port1_req, r1);

    // Randomised downloads: mostly sequential runs with jumps across both regions.
    for (int t = 0; t < 3; t++) begin
      start_dl("rand");
      cur = 25'($urandom_range(0, 63));
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 9) < 3)
          cur = ($urandom_range(0, 1) == 1) ? REGION2_BASE + 25'($urandom_range(0, 63))
                                            : 25'($urandom_range(0, 63));
        send_byte(($urandom_range(0, 7) == 0) ? 8'd1 : ROM_INDEX, cur, 8'($urandom));
        cur = cur + 25'd1;
      end
      finish_dl("rand");
      check("rand_overflow", overflow, 0);
    end

    // Reset while a port-1 write is outstanding with ack=1, req=0.
    ack_lat = 1;
    start_dl("rst");
    for (int k = 0; k < 2 && bus.port1_ack != 1'b1; k++) begin
      send_byte(8'd0, 25'h20, 8'hC0);
      send_byte(8'd0, 25'h21, 8'hC1);
      n = 0;
      while ((bus.port1_req != bus.port1_ack || exp1_q.size() != 0) && n < 100) begin
        @(negedge clk_sys);
        n++;
      end
    end
    check("rst_ack_primed", bus.port1_ack, 1);
    stall = 1'b1;
    send_byte(8'd0, 25'h22, 8'hD0);
    send_byte(8'd0, 25'h23, 8'hD1);
    check("rst_req_outstanding", bus.port1_req, 0);
    @(negedge clk_sys);
    reset       = 1'b1;
    ioctl_downl = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    check("rst_req_follows_ack", bus.port1_req, 1);
    check("rst_idle_empty", bus.port_we, 0);
    r1 = bus.port2_req;
    repeat (20) @(negedge clk_sys);
    check("rst_no_toggle", {bus.port1_req, bus.port2_req}, {1'b1, r1});
    stall = 1'b0;
    repeat (5) @(negedge clk_sys);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
